// File: rtl/cnn_layer_accel_pixel_fetch_if.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_pixel_fetch_if
// Bundles the three handshake/bus groups of the pixel fetch block:
//   job_fetch_*   row request / ack / complete handshake with the consumer
//   mem_rd_*      word read port (data returns one cycle after mem_rd_en)
//   pixel_*       valid/ready word stream to the consumer
// modport master : the fetch block side
// modport slave  : memory + consumer side
// ---------------------------------------------------------------------------
interface cnn_layer_accel_pixel_fetch_if #(
    parameter int C_PIXEL_WIDTH = 16,
    parameter int C_NUM_LANES   = 8,
    parameter int C_ADDR_WIDTH  = 16
);
    localparam int W = C_PIXEL_WIDTH * C_NUM_LANES;

    logic                    job_fetch_request;
    logic                    job_fetch_ack;
    logic                    job_fetch_complete;
    logic                    mem_rd_en;
    logic [C_ADDR_WIDTH-1:0] mem_rd_addr;
    logic [W-1:0]            mem_rd_data;
    logic                    pixel_valid;
    logic                    pixel_ready;
    logic [W-1:0]            pixel_data;

    modport master (
        input  job_fetch_request, mem_rd_data, pixel_ready,
        output job_fetch_ack, job_fetch_complete, mem_rd_en, mem_rd_addr,
               pixel_valid, pixel_data
    );

    modport slave (
        output job_fetch_request, mem_rd_data, pixel_ready,
        input  job_fetch_ack, job_fetch_complete, mem_rd_en, mem_rd_addr,
               pixel_valid, pixel_data
    );
endinterface

// File: rtl/cnn_layer_accel_pixel_fetch.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_pixel_fetch
// Streams a frame of depth-packed pixel words out of memory one row per
// downstream request. Each row is read in address order into a small buffer
// and handed out on a valid/ready stream.
// Ports:
//   clk_if, rst      clock, synchronous active-high reset
//   start, cfg_*     frame launch; cfg sampled with start while idle
//   busy, done       frame in progress / one-cycle frame-finished pulse
//   bus (master)     row handshake, memory read port, pixel stream
// ---------------------------------------------------------------------------
module cnn_layer_accel_pixel_fetch #(
    parameter int C_PIXEL_WIDTH = 16,
    parameter int C_NUM_LANES   = 8,
    parameter int C_ADDR_WIDTH  = 16,
    parameter int C_FIFO_DEPTH  = 4
) (
    input  logic                    clk_if,
    input  logic                    rst,
    input  logic                    start,
    input  logic [9:0]              cfg_num_rows,
    input  logic [9:0]              cfg_num_cols,
    input  logic [C_ADDR_WIDTH-1:0] cfg_base_addr,
    output logic                    busy,
    output logic                    done,
    cnn_layer_accel_pixel_fetch_if.master bus
);
    localparam int W  = C_PIXEL_WIDTH * C_NUM_LANES;
    localparam int PW = $clog2(C_FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT_REQ, S_ACK, S_STREAM, S_COMPLETE} state_t;

    state_t                  state_q, state_d;
    logic [9:0]              rows_q, rows_d, cols_q, cols_d;
    logic [9:0]              row_q, row_d;
    logic [C_ADDR_WIDTH-1:0] row_base_q, row_base_d;  // base + row*(cols+1), kept incrementally
    logic [10:0]             col_q, col_d;            // reads issued in this row
    logic [9:0]              xfer_q, xfer_d;          // words handed out in this row
    logic                    inflight_q, inflight_d;  // read issued last cycle, data due now
    logic [CW-1:0]           count_q, count_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [W-1:0]            fifo_q [C_FIFO_DEPTH];
    logic [W-1:0]            fifo_d [C_FIFO_DEPTH];

    logic                    rd_en, valid, pop;
    logic [CW-1:0]           occ;
    logic [C_ADDR_WIDTH-1:0] rd_addr;

    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        col_d      = col_q;
        xfer_d     = xfer_q;
        rd_en      = 1'b0;
        occ        = count_q + CW'(inflight_q);
        rd_addr    = row_base_q + C_ADDR_WIDTH'(col_q);
        // Stream is gated by state so nothing escapes outside a row.
        valid      = (state_q == S_STREAM) && (count_q != '0);
        pop        = valid && bus.pixel_ready;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rows_d     = cfg_num_rows;
                    cols_d     = cfg_num_cols;
                    row_d      = '0;
                    row_base_d = cfg_base_addr;
                    state_d    = S_WAIT_REQ;
                end
            end
            S_WAIT_REQ: begin
                if (bus.job_fetch_request) state_d = S_ACK;
            end
            S_ACK: begin
                col_d   = '0;
                xfer_d  = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                // Buffer slots are reserved at issue time so returning data
                // always has a place to land, whatever pixel_ready does.
                rd_en = (col_q <= {1'b0, cols_q}) && (occ < CW'(C_FIFO_DEPTH));
                if (rd_en) col_d = col_q + 11'd1;
                if (pop) begin
                    if (xfer_q == cols_q) state_d = S_COMPLETE;
                    else                  xfer_d  = xfer_q + 10'd1;
                end
            end
            S_COMPLETE: begin
                if (row_q == rows_q) begin
                    state_d = S_IDLE;
                end else begin
                    row_d      = row_q + 10'd1;
                    row_base_d = row_base_q + C_ADDR_WIDTH'({1'b0, cols_q} + 11'd1);
                    state_d    = S_WAIT_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        inflight_d = rd_en;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (inflight_q) begin
            fifo_d[wr_ptr_q] = bus.mem_rd_data;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(inflight_q) - CW'(pop);
    end

    always_ff @(posedge clk_if) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rows_q     <= '0;
            cols_q     <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            col_q      <= '0;
            xfer_q     <= '0;
            inflight_q <= 1'b0;  // late read data after reset is dropped
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            col_q      <= col_d;
            xfer_q     <= xfer_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage needs no reset: emptiness is carried by the pointers/count.
    always_ff @(posedge clk_if) begin
        fifo_q <= fifo_d;
    end

    assign busy                   = (state_q != S_IDLE);
    assign done                   = (state_q == S_COMPLETE) && (row_q == rows_q);
    assign bus.job_fetch_ack      = (state_q == S_ACK);
    assign bus.job_fetch_complete = (state_q == S_COMPLETE);
    assign bus.mem_rd_en          = rd_en;
    assign bus.mem_rd_addr        = rd_en ? rd_addr : '0;
    assign bus.pixel_valid        = valid;
    assign bus.pixel_data         = fifo_q[rd_ptr_q];
endmodule
